// File: rtl/noc_pe_interface.sv
`default_nettype none
// ============================================================================
// Module   : noc_pe_interface
// Brief    : PE-side mesh interface. TX FIFO injects packed flits into the
//            switch; RX FIFO captures non-stallable ejected flits for the PE.
// Revision : 1.0
// ============================================================================
module noc_pe_interface #(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_pe_valid,
  output logic                   o_pe_ready,
  input  logic [x_size-1:0]      i_pe_dest_x,
  input  logic [y_size-1:0]      i_pe_dest_y,
  input  logic [data_width-1:0]  i_pe_data,
  output logic                   o_sw_valid,
  input  logic                   i_sw_ready,
  output logic [total_width-1:0] o_sw_data,
  input  logic                   i_sw_valid,
  input  logic [total_width-1:0] i_sw_data,
  output logic                   o_rx_valid,
  input  logic                   i_rx_ready,
  output logic [data_width-1:0]  o_rx_data,
  output logic                   o_rx_src_ok,
  output logic [15:0]            o_drop_cnt,
  output logic [15:0]            o_tx_cnt
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int C_ADDR_W = x_size + y_size;
  localparam logic [C_ADDR_W-1:0] C_OWN_ADDR = {y_coord[y_size-1:0], x_coord[x_size-1:0]};
  localparam logic [TX_AW:0] C_TX_ONE = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] C_RX_ONE = {{RX_AW{1'b0}}, 1'b1};

  // ---------------- TX path ----------------
  logic [total_width-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_AW:0]         tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic                   tx_rdy_q, tx_rdy_d;
  logic [15:0]            tx_cnt_q;
  logic                   w_tx_empty, w_tx_push, w_tx_pop;

  assign w_tx_empty = (tx_wr_q == tx_rd_q);
  assign w_tx_push  = i_pe_valid & tx_rdy_q;
  assign w_tx_pop   = ~w_tx_empty & i_sw_ready;

  // Ready is registered from the post-update occupancy, so a pop from full
  // only reopens the input on the following cycle.
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (w_tx_push) tx_wr_d = tx_wr_q + C_TX_ONE;
    if (w_tx_pop)  tx_rd_d = tx_rd_q + C_TX_ONE;
    tx_rdy_d = ~((tx_wr_d[TX_AW] != tx_rd_d[TX_AW]) &&
                 (tx_wr_d[TX_AW-1:0] == tx_rd_d[TX_AW-1:0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_rdy_q <= 1'b1;
      tx_cnt_q <= 16'd0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_rdy_q <= tx_rdy_d;
      if (w_tx_pop) tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_tx_push)
      tx_mem_q[tx_wr_q[TX_AW-1:0]] <= {i_pe_data, i_pe_dest_y, i_pe_dest_x};
  end

  assign o_pe_ready = tx_rdy_q;
  assign o_sw_valid = ~w_tx_empty;
  assign o_sw_data  = tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign o_tx_cnt   = tx_cnt_q;

  // ---------------- RX path ----------------
  logic [total_width-1:0] rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]         rx_wr_q, rx_rd_q;
  logic [15:0]            drop_q;
  logic                   w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_drop;
  logic [total_width-1:0] w_rx_head;

  assign w_rx_empty = (rx_wr_q == rx_rd_q);
  assign w_rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign w_rx_pop   = ~w_rx_empty & i_rx_ready;
  // A full FIFO still takes the flit when the head leaves in the same cycle.
  assign w_rx_push  = i_sw_valid & (~w_rx_full | w_rx_pop);
  assign w_rx_drop  = i_sw_valid & w_rx_full & ~w_rx_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      drop_q  <= 16'd0;
    end else begin
      if (w_rx_push) rx_wr_q <= rx_wr_q + C_RX_ONE;
      if (w_rx_pop)  rx_rd_q <= rx_rd_q + C_RX_ONE;
      if (w_rx_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_rx_push)
      rx_mem_q[rx_wr_q[RX_AW-1:0]] <= i_sw_data;
  end

  assign w_rx_head   = rx_mem_q[rx_rd_q[RX_AW-1:0]];
  assign o_rx_valid  = ~w_rx_empty;
  assign o_rx_data   = w_rx_head[total_width-1 -: data_width];
  assign o_rx_src_ok = (w_rx_head[C_ADDR_W-1:0] == C_OWN_ADDR);
  assign o_drop_cnt  = drop_q;

endmodule
`default_nettype wire
